// File: rtl/gpmc_reg_bank_if.sv
// Host bus as seen downstream of the GPMC clock-domain synchronizer.
// Strobes are active low. data_out carries host write data toward the
// register bank, and data_in carries read data back to the synchronizer.
interface gpmc_reg_bank_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  cs;
  logic                  we;
  logic                  oe;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;

  // Synchronizer side: drives strobes, address and write data.
  modport master (
    output cs, we, oe, address, data_out,
    input  data_in
  );

  // Register bank side: consumes strobes and returns read data.
  modport slave (
    input  cs, we, oe, address, data_out,
    output data_in
  );
endinterface

// File: rtl/gpmc_reg_bank.sv
// Host register bank and frame-buffer write front end.
// It detects host write and read events from the synchronized strobes,
// decodes the control/status map and drives the back-bank write port.
// A vsync-aligned swap handshake flips the front bank at the frame boundary.
module gpmc_reg_bank #(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    FB_ADDR_WIDTH = 11,
  parameter int                    FB_DEPTH      = 2048,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE      = 16'h4F50
) (
  input  logic                     clk,
  input  logic                     rst,
  gpmc_reg_bank_if.slave           bus,
  output logic                     fb_we,
  output logic                     fb_bank,
  output logic [FB_ADDR_WIDTH-1:0] fb_waddr,
  output logic [DATA_WIDTH-1:0]    fb_wdata,
  input  logic                     frame_start,
  output logic                     front_bank,
  output logic                     display_en,
  output logic [7:0]               brightness
);

  localparam logic [ADDR_WIDTH-1:0]    ADDR_ID      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0]    ADDR_CTRL    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]    ADDR_STATUS  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0]    ADDR_FB_PTR  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0]    ADDR_FB_DATA = ADDR_WIDTH'(4);
  localparam logic [FB_ADDR_WIDTH-1:0] PTR_LAST     = FB_ADDR_WIDTH'(FB_DEPTH - 1);

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_e;

  // Registered state
  swap_state_e              state_q, state_d;
  logic                     we_hist_q, we_hist_d;
  logic                     oe_hist_q, oe_hist_d;
  logic                     display_en_q, display_en_d;
  logic [7:0]               brightness_q, brightness_d;
  logic [FB_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]               frame_cnt_q, frame_cnt_d;
  logic                     front_bank_q, front_bank_d;
  logic                     fb_we_q, fb_we_d;
  logic                     fb_bank_q, fb_bank_d;
  logic [FB_ADDR_WIDTH-1:0] fb_waddr_q, fb_waddr_d;
  logic [DATA_WIDTH-1:0]    fb_wdata_q, fb_wdata_d;
  logic [DATA_WIDTH-1:0]    data_in_q, data_in_d;

  // Decode helpers
  logic                     wr_event;
  logic                     rd_event;
  logic                     is_direct;
  logic [ADDR_WIDTH-2:0]    direct_off;
  logic                     direct_ok;
  logic [FB_ADDR_WIDTH-1:0] ptr_wval;
  logic                     ptr_ok;
  logic                     swap_pending;
  logic                     swap_write;
  logic [15:0]              ctrl_rd;
  logic [15:0]              status_rd;

  // The direct-write offset is the full address below the flag bit, so an
  // offset past the bank is rejected rather than silently aliasing.
  assign wr_event     = ~bus.cs & ~bus.we & we_hist_q;
  assign rd_event     = ~bus.cs & ~bus.oe & oe_hist_q;
  assign is_direct    = bus.address[ADDR_WIDTH-1];
  assign direct_off   = bus.address[ADDR_WIDTH-2:0];
  assign direct_ok    = {1'b0, direct_off} < ADDR_WIDTH'(FB_DEPTH);
  assign ptr_wval     = bus.data_out[FB_ADDR_WIDTH-1:0];
  assign ptr_ok       = {1'b0, ptr_wval} < (FB_ADDR_WIDTH + 1)'(FB_DEPTH);
  assign swap_pending = (state_q == PENDING);
  assign ctrl_rd      = {brightness_q, 6'b0, swap_pending, display_en_q};
  assign status_rd    = {frame_cnt_q, 6'b0, front_bank_q, swap_pending};

  // Next-state logic: event decode, register writes, FB port, swap FSM, reads.
  always_comb begin
    state_d      = state_q;
    we_hist_d    = bus.we;
    oe_hist_d    = bus.oe;
    display_en_d = display_en_q;
    brightness_d = brightness_q;
    ptr_d        = ptr_q;
    frame_cnt_d  = frame_cnt_q;
    front_bank_d = front_bank_q;
    fb_we_d      = 1'b0;
    fb_bank_d    = fb_bank_q;
    fb_waddr_d   = fb_waddr_q;
    fb_wdata_d   = fb_wdata_q;
    data_in_d    = data_in_q;
    swap_write   = 1'b0;

    if (frame_start) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if (wr_event) begin
      if (is_direct) begin
        if (direct_ok) begin
          fb_we_d    = 1'b1;
          fb_waddr_d = direct_off[FB_ADDR_WIDTH-1:0];
          fb_wdata_d = bus.data_out;
        end
      end else begin
        case (bus.address)
          ADDR_CTRL: begin
            display_en_d = bus.data_out[0];
            brightness_d = bus.data_out[15:8];
            swap_write   = bus.data_out[1];
          end
          ADDR_FB_PTR: begin
            ptr_d = ptr_ok ? ptr_wval : '0;
          end
          ADDR_FB_DATA: begin
            fb_we_d    = 1'b1;
            fb_waddr_d = ptr_q;
            fb_wdata_d = bus.data_out;
            ptr_d      = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
          end
          default: begin
          end
        endcase
      end
    end

    // A request landing together with frame_start in IDLE only arms the
    // swap; the flip waits for the following frame boundary.
    case (state_q)
      IDLE: begin
        if (swap_write) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          front_bank_d = ~front_bank_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The write port always targets the bank the display is not reading.
    if (fb_we_d || (front_bank_d != front_bank_q)) begin
      fb_bank_d = ~front_bank_d;
    end

    if (rd_event) begin
      data_in_d = '0;
      if (!is_direct) begin
        case (bus.address)
          ADDR_ID:     data_in_d = ID_VALUE;
          ADDR_CTRL:   data_in_d = DATA_WIDTH'(ctrl_rd);
          ADDR_STATUS: data_in_d = DATA_WIDTH'(status_rd);
          ADDR_FB_PTR: data_in_d = DATA_WIDTH'(ptr_q);
          default:     data_in_d = '0;
        endcase
      end
    end
  end

  // State registers; strobe history resets high so release creates no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_hist_q    <= 1'b1;
      oe_hist_q    <= 1'b1;
      display_en_q <= 1'b0;
      brightness_q <= '0;
      ptr_q        <= '0;
      frame_cnt_q  <= '0;
      front_bank_q <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_bank_q    <= 1'b0;
      fb_waddr_q   <= '0;
      fb_wdata_q   <= '0;
      data_in_q    <= '0;
    end else begin
      state_q      <= state_d;
      we_hist_q    <= we_hist_d;
      oe_hist_q    <= oe_hist_d;
      display_en_q <= display_en_d;
      brightness_q <= brightness_d;
      ptr_q        <= ptr_d;
      frame_cnt_q  <= frame_cnt_d;
      front_bank_q <= front_bank_d;
      fb_we_q      <= fb_we_d;
      fb_bank_q    <= fb_bank_d;
      fb_waddr_q   <= fb_waddr_d;
      fb_wdata_q   <= fb_wdata_d;
      data_in_q    <= data_in_d;
    end
  end

  assign bus.data_in = data_in_q;
  assign fb_we       = fb_we_q;
  assign fb_bank     = fb_bank_q;
  assign fb_waddr    = fb_waddr_q;
  assign fb_wdata    = fb_wdata_q;
  assign front_bank  = front_bank_q;
  assign display_en  = display_en_q;
  assign brightness  = brightness_q;

endmodule

// File: tb/tb_gpmc_reg_bank.sv
// Directed bench for gpmc_reg_bank: register map, FB write port,
// swap handshake, frame counter wrap and asynchronous reset.
module tb_gpmc_reg_bank;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int FAW = 11;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           frame_start;
  logic           fb_we;
  logic           fb_bank;
  logic [FAW-1:0] fb_waddr;
  logic [DW-1:0]  fb_wdata;
  logic           front_bank;
  logic           display_en;
  logic [7:0]     brightness;

  gpmc_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  gpmc_reg_bank dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .fb_we       (fb_we),
    .fb_bank     (fb_bank),
    .fb_waddr    (fb_waddr),
    .fb_wdata    (fb_wdata),
    .frame_start (frame_start),
    .front_bank  (front_bank),
    .display_en  (display_en),
    .brightness  (brightness)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic           snapWe;
  logic           snapWeAfter;
  logic           snapBank;
  logic [FAW-1:0] snapAddr;
  logic [DW-1:0]  snapData;
  logic [DW-1:0]  rdData;
  logic [DW-1:0]  rdHeld;
  int             weCount;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic cs, input logic we, input logic oe,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.cs       = cs;
    bus.we       = we;
    bus.oe       = oe;
    bus.address  = addr;
    bus.data_out = data;
  endtask

  task automatic hostWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, addr, data);
    tick();
    snapWe   = fb_we;
    snapBank = fb_bank;
    snapAddr = fb_waddr;
    snapData = fb_wdata;
    applyStimulus(1'b1, 1'b1, 1'b1, addr, data);
    tick();
    snapWeAfter = fb_we;
  endtask

  task automatic hostRead(input logic [AW-1:0] addr);
    applyStimulus(1'b0, 1'b1, 1'b0, addr, '0);
    tick();
    rdData = bus.data_in;
    applyStimulus(1'b1, 1'b1, 1'b1, addr, '0);
    tick();
    rdHeld = bus.data_in;
  endtask

  task automatic pulseFrame(input int count);
    for (int i = 0; i < count; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  initial begin
    frame_start = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0);
    #2 rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_fb_we", 32'(fb_we), 32'd0);
    checkOutput("rst_front_bank", 32'(front_bank), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("rel_fb_we", 32'(fb_we), 32'd0);
    checkOutput("rel_fb_bank", 32'(fb_bank), 32'd0);
    checkOutput("rel_fb_waddr", 32'(fb_waddr), 32'd0);
    checkOutput("rel_fb_wdata", 32'(fb_wdata), 32'd0);
    checkOutput("rel_data_in", 32'(bus.data_in), 32'd0);
    checkOutput("rel_display_en", 32'(display_en), 32'd0);
    checkOutput("rel_brightness", 32'(brightness), 32'd0);

    hostRead(16'h0000);
    checkOutput("id_read", 32'(rdData), 32'h4F50);
    checkOutput("id_held", 32'(rdHeld), 32'h4F50);
    hostWrite(16'h0000, 16'hFFFF);
    hostRead(16'h0000);
    checkOutput("id_readonly", 32'(rdData), 32'h4F50);
    hostRead(16'h0010);
    checkOutput("unmapped_read", 32'(rdData), 32'h0000);

    $display("[TB] pointer wrap");
    hostWrite(16'h0003, 16'd2046);
    checkOutput("ptr_write_no_fbwe", 32'(snapWe), 32'd0);
    hostWrite(16'h0004, 16'hAAAA);
    checkOutput("fbd0_we", 32'(snapWe), 32'd1);
    checkOutput("fbd0_addr", 32'(snapAddr), 32'd2046);
    checkOutput("fbd0_data", 32'(snapData), 32'hAAAA);
    checkOutput("fbd0_bank", 32'(snapBank), 32'd1);
    checkOutput("fbd0_one_cycle", 32'(snapWeAfter), 32'd0);
    hostWrite(16'h0004, 16'hBBBB);
    checkOutput("fbd1_addr", 32'(snapAddr), 32'd2047);
    checkOutput("fbd1_data", 32'(snapData), 32'hBBBB);
    hostWrite(16'h0004, 16'hCCCC);
    checkOutput("fbd2_we", 32'(snapWe), 32'd1);
    checkOutput("fbd2_addr", 32'(snapAddr), 32'd0);
    checkOutput("fbd2_bank", 32'(snapBank), 32'd1);
    hostRead(16'h0003);
    checkOutput("ptr_after_wrap", 32'(rdData), 32'd1);
    hostRead(16'h0004);
    checkOutput("fbdata_read_zero", 32'(rdData), 32'd0);

    $display("[TB] ctrl and swap");
    hostWrite(16'h0001, 16'h8003);
    checkOutput("ctrl_display_en", 32'(display_en), 32'd1);
    checkOutput("ctrl_brightness", 32'(brightness), 32'h80);
    hostRead(16'h0002);
    checkOutput("status_pending", 32'(rdData), 32'h0001);
    hostRead(16'h0001);
    checkOutput("ctrl_readback", 32'(rdData), 32'h8003);
    pulseFrame(1);
    checkOutput("swap1_front", 32'(front_bank), 32'd1);
    checkOutput("swap1_fb_bank", 32'(fb_bank), 32'd0);
    hostRead(16'h0002);
    checkOutput("swap1_status", 32'(rdData), 32'h0102);

    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0001, 16'h8003);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0001, 16'h8003);
    tick();
    checkOutput("simul_no_toggle", 32'(front_bank), 32'd1);
    hostRead(16'h0002);
    checkOutput("simul_status", 32'(rdData), 32'h0203);
    pulseFrame(1);
    checkOutput("simul_next_toggle", 32'(front_bank), 32'd0);
    checkOutput("simul_fb_bank", 32'(fb_bank), 32'd1);
    hostWrite(16'h0001, 16'h8003);
    hostWrite(16'h0001, 16'h8003);
    pulseFrame(1);
    checkOutput("double_req_toggle", 32'(front_bank), 32'd1);
    pulseFrame(1);
    checkOutput("double_req_once", 32'(front_bank), 32'd1);
    hostRead(16'h0002);
    checkOutput("double_req_status", 32'(rdData), 32'h0502);

    $display("[TB] direct writes");
    hostWrite(16'h8005, 16'h1234);
    checkOutput("direct_we", 32'(snapWe), 32'd1);
    checkOutput("direct_addr", 32'(snapAddr), 32'd5);
    checkOutput("direct_data", 32'(snapData), 32'h1234);
    checkOutput("direct_bank", 32'(snapBank), 32'd0);
    hostRead(16'h0003);
    checkOutput("direct_ptr_unchanged", 32'(rdData), 32'd1);
    hostWrite(16'h8800, 16'h5678);
    checkOutput("direct_oob_dropped", 32'(snapWe), 32'd0);
    weCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h8007, 16'h55AA);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fb_we) weCount++;
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h8007, 16'h55AA);
    tick();
    if (fb_we) weCount++;
    checkOutput("held_we_single", 32'(weCount), 32'd1);

    $display("[TB] reset mid-operation");
    pulseFrame(250);
    hostWrite(16'h0001, 16'h8003);
    hostWrite(16'h0003, 16'd100);
    hostRead(16'h0002);
    checkOutput("pre_rst_status", 32'(rdData), 32'hFF03);
    hostRead(16'h0003);
    checkOutput("pre_rst_ptr", 32'(rdData), 32'd100);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("mid_rst_front", 32'(front_bank), 32'd0);
    checkOutput("mid_rst_display_en", 32'(display_en), 32'd0);
    checkOutput("mid_rst_brightness", 32'(brightness), 32'd0);
    checkOutput("mid_rst_data_in", 32'(bus.data_in), 32'd0);
    checkOutput("mid_rst_fb_waddr", 32'(fb_waddr), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    hostRead(16'h0002);
    checkOutput("post_rst_status", 32'(rdData), 32'h0000);
    hostRead(16'h0003);
    checkOutput("post_rst_ptr", 32'(rdData), 32'd0);
    hostRead(16'h0001);
    checkOutput("post_rst_ctrl", 32'(rdData), 32'd0);
    pulseFrame(255);
    checkOutput("cancelled_swap", 32'(front_bank), 32'd0);
    hostRead(16'h0002);
    checkOutput("frame_cnt_255", 32'(rdData), 32'hFF00);
    pulseFrame(1);
    hostRead(16'h0002);
    checkOutput("frame_cnt_wrap", 32'(rdData), 32'h0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
